ps2_kbd_decoder: RTL
====================

// Module: ps2_kbd_decoder
// PURPOSE
// Consumes the emulated PS/2 keyboard serial stream (ps2_kbd_clk/ps2_kbd_data) produced by hps_io in the
// clk_sys domain and converts it to key events for the core's keyboard matrix logic.
// - Deserialises 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
// - Folds E0/F0 prefixes into flags and queues {released, extended, code} events in a FIFO.
// - Presents the FIFO head through a valid/ready interface.
// PARAMETERS
// TIMEOUT     4095  clk_sys cycles without a ps2_kbd_clk falling edge before a partial frame is aborted
// FIFO_AW     3     log2 of event FIFO depth (8 entries)
// PORTS
// clk_sys       in   1  system clock, same clock as hps_io
// reset         in   1  synchronous, active-high reset
// ps2_kbd_clk   in   1  PS/2 clock from hps_io; idles high
// ps2_kbd_data  in   1  PS/2 data from hps_io; sampled on ps2_kbd_clk falling edge
// key_valid     out  1  FIFO non-empty; head event is on key_code/key_extended/key_released
// key_ready     in   1  consumer accepts the head event when key_valid & key_ready
// key_code      out  8  scancode, set 2, with prefixes stripped
// key_extended  out  1  event was preceded by E0
// key_released  out  1  event was preceded by F0
// frame_err     out  1  one-cycle strobe: bad start, parity, stop, or timeout
// overflow      out  1  sticky: an event was dropped on a full FIFO; cleared only by reset
// BEHAVIOUR
// - Clock and reset: one clock, clk_sys. Reset is synchronous and active-high.
// - Reset values: all outputs 0, FIFO empty, state IDLE, prefix flags clear. The edge detector's previous
//   value resets to 1.
// - Reset in mid-frame discards the partial byte and the pending prefixes.
// - Edge detect: fall = prev_clk & ~ps2_kbd_clk, where prev_clk is registered ps2_kbd_clk.
//   No synchroniser is used because the source is in the same clock domain.
// - FSM, advanced only on a fall:
//   - IDLE: on data=0 go to DATA with bit count 0. On data=1 stay in IDLE; this is not an error.
//   - DATA: shift data into bit 7 of the shift register (right shift). After the 8th bit go to PARITY.
//   - PARITY: capture the bit, then go to STOP.
//   - STOP: check the stop and parity bits, then go to IDLE.
//     Frame OK requires stop=1 and parity bit = ~^byte (odd parity).
//     Frame OK means the byte goes to the decoder. Otherwise pulse frame_err for 1 cycle and clear the prefix flags.
// - Timeout: in any state except IDLE, a counter counts cycles since the last fall.
//   At TIMEOUT the FSM returns to IDLE, frame_err pulses, and the prefix flags clear.
//   The counter resets on every fall.
// - Decoder: acts in the cycle after the STOP fall.
//   - Byte E0: set ext.
//   - Byte F0: set rel.
//   - Any other byte: push {rel, ext, byte} and clear both flags. This includes E1, which gets no special treatment.
//   - Flags persist across frames until an event is pushed or an error occurs.
// - FIFO: 2^FIFO_AW entries. Pointers are FIFO_AW+1 bits wide and wrap naturally.
//   - Full: MSBs differ and the low bits are equal.
//   - key_valid = ~empty. Outputs are driven combinationally from the head entry.
//   - Pop when key_valid & key_ready. The next entry appears in the following cycle.
//   - Push while full and with no pop in the same cycle: the event is dropped, overflow is set, and the flags still clear.
//   - Simultaneous push and pop while full: both happen and nothing is dropped.
//   - Simultaneous push and pop while empty: the push lands and the pop is ignored, since valid was 0.
// - Latency: key_valid rises 2 cycles after the clk_sys cycle in which the STOP fall is detected, when the FIFO was empty.
// TESTING
// - Frame 0x1C with parity 0 and stop 1, ready held 1: key_valid pulses 1 cycle. key_code=1C, ext=0, rel=0. frame_err=0.
// - Sequence E0,F0,75: exactly one event, code=75, ext=1, rel=1. The next byte 75 gives ext=0, rel=0.
// - Frame 0x1C with parity 1: frame_err pulses once and no event is queued. A following valid 0x1C is queued normally.
// - 4 bits sent, then the clock held high for TIMEOUT+1 cycles:
//   - frame_err pulses once and the FSM returns to IDLE.
//   - A following full 0x29 frame decodes correctly.
// - key_ready=0 and 9 bytes 0x01..0x09 sent:
//   - overflow=1 and the FIFO holds 01..08.
//   - Draining with ready=1 returns 01..08 in order, then key_valid=0.
// - Reset asserted 1 cycle mid-DATA after a pending F0, then 0x1C sent: event code=1C, rel=0. overflow=0.

Source files
------------

// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder: deserialises PS/2 keyboard frames, folds E0/F0 prefixes into flags
// and queues {released, extended, code} key events behind a valid/ready FIFO.
module ps2_kbd_decoder #(
  parameter int TIMEOUT = 4095,
  parameter int FIFO_AW = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       frame_err,
  output logic       overflow
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t               state_q;
  logic                 prev_clk_q;
  logic [2:0]           cnt_q;
  logic [7:0]           shift_q;
  logic                 par_q;
  logic [TW-1:0]        tmr_q;
  logic                 byte_vld_q;
  logic [7:0]           byte_q;
  logic                 ext_q, rel_q;
  logic                 frame_err_q, overflow_q;
  logic [9:0]           mem_q [2**FIFO_AW];
  logic [FIFO_AW:0]     wptr_q, rptr_q;
  logic                 fall, timeout, frame_ok, err, empty, full, push, pop, wr;
  always_comb begin
    fall     = prev_clk_q & ~ps2_kbd_clk;
    timeout  = (state_q != IDLE) && !fall && (tmr_q == TW'(TIMEOUT - 1));
    frame_ok = ps2_kbd_data && (par_q == ~^shift_q);
    err      = timeout || (fall && state_q == STOP && !frame_ok);
    empty    = wptr_q == rptr_q;
    full     = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
               (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    push     = byte_vld_q && byte_q != 8'hE0 && byte_q != 8'hF0;
    pop      = !empty && key_ready;
    wr       = push && (!full || pop);
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      prev_clk_q  <= 1'b1;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmr_q       <= '0;
      byte_vld_q  <= 1'b0;
      byte_q      <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      prev_clk_q  <= ps2_kbd_clk;
      frame_err_q <= err;
      byte_vld_q  <= 1'b0;
      tmr_q       <= (fall || state_q == IDLE) ? '0 : tmr_q + 1'b1;
      if (timeout) state_q <= IDLE;
      else if (fall) begin
        case (state_q)
          IDLE: if (!ps2_kbd_data) begin
            state_q <= DATA;
            cnt_q   <= '0;
          end
          DATA: begin
            shift_q <= {ps2_kbd_data, shift_q[7:1]};
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= ps2_kbd_data;
            state_q <= STOP;
          end
          STOP: begin
            state_q    <= IDLE;
            byte_vld_q <= frame_ok;
            byte_q     <= shift_q;
          end
        endcase
      end
      // Prefix flags survive across frames until an event is queued or a frame fails
      if (err || push) begin
        ext_q <= 1'b0;
        rel_q <= 1'b0;
      end else if (byte_vld_q) begin
        ext_q <= ext_q | (byte_q == 8'hE0);
        rel_q <= rel_q | (byte_q == 8'hF0);
      end
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (push && !wr) overflow_q <= 1'b1;
    end
  end
  always_ff @(posedge clk_sys) begin
    if (wr) mem_q[wptr_q[FIFO_AW-1:0]] <= {rel_q, ext_q, byte_q};
  end
  always_comb begin
    key_valid = !empty;
    {key_released, key_extended, key_code} = empty ? 10'd0 : mem_q[rptr_q[FIFO_AW-1:0]];
    frame_err = frame_err_q;
    overflow  = overflow_q;
  end
endmodule
